// File: rtl/fifo_pkg.sv
// Shared FIFO constants and the write-arbiter state type.
package fifo_pkg;

    localparam int FIFO_W     = 8;
    localparam int FIFO_DEPTH = 16;
    localparam int BURST_MAX  = 15;

    typedef enum logic {
        IDLE,
        OWN
    } arb_state_t;

endpackage : fifo_pkg

// File: rtl/fifo_wr_arb_rr_pick.sv
// Round-robin picker: the first requester after `last` (modulo N) wins,
// so the most recent owner is considered last.
module rr_pick #(
    parameter int N  = 2,
    parameter int IW = 1
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] last,
    output logic          any,
    output logic [IW-1:0] idx
);

    // Scan from the farthest offset down so the nearest requester overwrites.
    always_comb begin
        any = 1'b0;
        idx = last;
        for (int unsigned off = N; off >= 1; off--) begin
            if (req[IW'((32'(last) + off) % N)]) begin
                any = 1'b1;
                idx = IW'((32'(last) + off) % N);
            end
        end
    end

endmodule : rr_pick

// File: rtl/fifo_wr_arb.sv
// Round-robin write arbiter sharing the single FIFO write port between N
// valid/ready producers, granting bounded bursts and stalling on full.
module fifo_wr_arb
    import fifo_pkg::*;
#(
    parameter int N     = 2,
    parameter int W     = FIFO_W,
    parameter int BURST = 4
) (
    input  logic           ck,
    input  logic           rst,
    input  logic [N-1:0]   req_valid,
    input  logic [N*W-1:0] req_data,
    output logic [N-1:0]   req_ready,
    output logic [W-1:0]   fifo_din,
    output logic           fifo_wen,
    input  logic           fifo_full,
    output logic [N-1:0]   gnt,
    output logic           busy
);

    localparam int IW = $clog2(N);
    localparam logic [3:0] CNT_LAST = 4'(BURST - 1);

    if (N < 2 || N > 4) begin : g_bad_n
        $error("fifo_wr_arb: N must be in 2..4");
    end
    if (BURST < 1 || BURST > BURST_MAX) begin : g_bad_burst
        $error("fifo_wr_arb: BURST must be in 1..BURST_MAX");
    end

    arb_state_t    state_q, state_d;
    logic [N-1:0]  gnt_q,   gnt_d;
    logic [IW-1:0] last_q,  last_d;
    logic [3:0]    cnt_q,   cnt_d;

    logic          pick_any;
    logic [IW-1:0] pick_idx;
    logic          owner_valid;
    logic          beat;
    logic          own_release;

    rr_pick #(
        .N  (N),
        .IW (IW)
    ) u_pick (
        .req  (req_valid),
        .last (last_q),
        .any  (pick_any),
        .idx  (pick_idx)
    );

    // While owning, last_q always holds the owner index, so it doubles as g.
    always_comb begin
        busy        = (state_q == OWN);
        owner_valid = req_valid[last_q];
        req_ready   = gnt_q & {N{~fifo_full}};
        beat        = busy & owner_valid & ~fifo_full;
        fifo_wen    = beat;
        fifo_din    = busy ? req_data[last_q*W +: W] : '0;
        gnt         = gnt_q;
    end

    // Grant, handoff and burst counting; handoff reuses the picker in the same edge.
    always_comb begin
        state_d     = state_q;
        gnt_d       = gnt_q;
        last_d      = last_q;
        cnt_d       = cnt_q;
        own_release = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (pick_any) begin
                    state_d          = OWN;
                    gnt_d            = '0;
                    gnt_d[pick_idx]  = 1'b1;
                    last_d           = pick_idx;
                    cnt_d            = '0;
                end
            end
            OWN: begin
                own_release = ~owner_valid | (beat & (cnt_q == CNT_LAST));
                if (own_release) begin
                    cnt_d = '0;
                    if (pick_any) begin
                        gnt_d           = '0;
                        gnt_d[pick_idx] = 1'b1;
                        last_d          = pick_idx;
                    end else begin
                        state_d = IDLE;
                        gnt_d   = '0;
                    end
                end else if (beat) begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            default: begin
                state_d = IDLE;
                gnt_d   = '0;
                cnt_d   = '0;
            end
        endcase
    end

    // State registers; after reset producer 0 has top priority.
    always_ff @(posedge ck or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            gnt_q   <= '0;
            last_q  <= IW'(N - 1);
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule : fifo_wr_arb

// File: tb/tb_fifo_wr_arb.sv
// Scoreboard bench for fifo_wr_arb with a behavioural arbiter/FIFO model.
module tb_fifo_wr_arb;
    import fifo_pkg::*;

    localparam int N     = 2;
    localparam int W     = 8;
    localparam int BURST = 4;

    logic           ck = 1'b0;
    logic           rst = 1'b1;
    logic [N-1:0]   req_valid = '0;
    logic [N*W-1:0] req_data = '0;
    logic [N-1:0]   req_ready;
    logic [W-1:0]   fifo_din;
    logic           fifo_wen;
    logic           fifo_full = 1'b0;
    logic [N-1:0]   gnt;
    logic           busy;

    logic [2:0]  v3 = '0;
    logic [23:0] d3 = '0;
    logic [2:0]  rdy3, gnt3;
    logic [7:0]  din3;
    logic        wen3, busy3;
    logic        f3 = 1'b0;

    fifo_wr_arb #(.N(N), .W(W), .BURST(BURST)) dut (
        .ck(ck), .rst(rst), .req_valid(req_valid), .req_data(req_data),
        .req_ready(req_ready), .fifo_din(fifo_din), .fifo_wen(fifo_wen),
        .fifo_full(fifo_full), .gnt(gnt), .busy(busy)
    );

    fifo_wr_arb #(.N(3), .W(8), .BURST(1)) u3 (
        .ck(ck), .rst(rst), .req_valid(v3), .req_data(d3),
        .req_ready(rdy3), .fifo_din(din3), .fifo_wen(wen3),
        .fifo_full(f3), .gnt(gnt3), .busy(busy3)
    );

    always #5 ck = ~ck;

    typedef struct {
        logic [N-1:0] gnt;
        logic [N-1:0] rdy;
        logic         wen;
        logic         busy;
        logic [W-1:0] din;
    } exp_t;

    exp_t         exp_q[$];
    logic [W-1:0] dat_q[$];
    logic [W-1:0] wr_log[$];

    int checks = 0;
    int errors = 0;

    // Environment: FIFO occupancy and producer knobs.
    int wr_cnt = 0, rd_cnt = 0;
    int rd_pct = 0, drop_pct = 0;
    bit rd_once = 0;
    int raise_pct[N];
    int nxt[N];
    int lim[N];
    logic [N-1:0] beat_seen = '0;

    // Reference model: owner (-1 = idle), most recent owner, beats in grant.
    int m_own, m_last, m_cnt, m_cur;
    bit m_beat;

    task automatic chk(input string nm, input int act, input int expv);
        checks++;
        if (act != expv) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, expv, $time);
        end
    endtask

    function automatic int pick(input logic [N-1:0] val, input int last);
        for (int k = 1; k <= N; k++) begin
            int j;
            j = (last + k) % N;
            if (val[j]) return j;
        end
        return -1;
    endfunction

    task automatic model_reset();
        m_own = -1; m_last = N - 1; m_cnt = 0; m_beat = 0; m_cur = -1;
    endtask

    task automatic model_out();
        exp_t e;
        e.gnt = '0; e.rdy = '0; e.wen = 0; e.busy = 0; e.din = '0;
        m_beat = 0;
        if (rst) begin
            model_reset();
        end else if (m_own >= 0) begin
            e.gnt[m_own] = 1'b1;
            e.busy = 1;
            e.din  = req_data[m_own*W +: W];
            e.rdy  = fifo_full ? '0 : e.gnt;
            m_beat = req_valid[m_own] && !fifo_full;
            e.wen  = m_beat;
            if (m_beat) dat_q.push_back(e.din);
        end
        m_cur = m_own;
        exp_q.push_back(e);
    endtask

    task automatic model_adv();
        int p;
        if (rst) return;
        p = pick(req_valid, m_last);
        if (m_own < 0) begin
            if (p >= 0) begin m_own = p; m_last = p; m_cnt = 0; end
        end else if (!req_valid[m_own] || (m_beat && m_cnt == BURST - 1)) begin
            m_own = p;
            if (p >= 0) m_last = p;
            m_cnt = 0;
        end else if (m_beat) begin
            m_cnt++;
        end
    endtask

    task automatic drive();
        if ((rd_once || $urandom_range(99) < rd_pct) && (wr_cnt - rd_cnt) > 0) rd_cnt++;
        rd_once = 0;
        for (int i = 0; i < N; i++) begin
            if (beat_seen[i]) begin
                if (nxt[i] > lim[i] || $urandom_range(99) < drop_pct) begin
                    req_valid[i] = 1'b0;
                end else begin
                    req_data[i*W +: W] = W'(nxt[i]);
                    nxt[i]++;
                end
            end else if (!req_valid[i] && nxt[i] <= lim[i] && $urandom_range(99) < raise_pct[i]) begin
                req_valid[i] = 1'b1;
                req_data[i*W +: W] = W'(nxt[i]);
                nxt[i]++;
            end
        end
        fifo_full = (wr_cnt - rd_cnt) >= FIFO_DEPTH;
    endtask

    task automatic cycle();
        @(posedge ck);
        #1 drive();
        #1 model_out();
        model_adv();
    endtask

    task automatic do_reset(input bit keep_valid);
        int had;
        rst = 1'b1;
        if (!keep_valid) req_valid = '0;
        v3 = '0;
        wr_cnt = 0; rd_cnt = 0; fifo_full = 0;
        had = exp_q.size();
        exp_q.delete();
        dat_q.delete();
        model_reset();
        if (had > 0) model_out();
        for (int i = 0; i < N; i++) raise_pct[i] = 0;
        repeat (2) cycle();
        rst = 1'b0;
        model_adv();
        wr_log.delete();
    endtask

    task automatic monitor();
        exp_t e;
        forever begin
            @(negedge ck);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("gnt", int'(gnt), int'(e.gnt));
                chk("req_ready", int'(req_ready), int'(e.rdy));
                chk("fifo_wen", int'(fifo_wen), int'(e.wen));
                chk("busy", int'(busy), int'(e.busy));
                chk("fifo_din", int'(fifo_din), int'(e.din));
            end
            if (fifo_full) chk("wen_while_full", int'(fifo_wen), 0);
            if (fifo_wen) begin
                wr_log.push_back(fifo_din);
                if (!fifo_full) wr_cnt++;
                if (dat_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL beat_order: got write 0x%0h expected no write at %0t", fifo_din, $time);
                end else begin
                    chk("beat_data", int'(fifo_din), int'(dat_q.pop_front()));
                end
            end
            beat_seen = fifo_wen ? req_ready : '0;
        end
    endtask

    initial begin
        int expv;
        bit found;
        fork monitor(); join_none
        for (int i = 0; i < N; i++) begin raise_pct[i] = 0; nxt[i] = 0; lim[i] = 1 << 30; end
        do_reset(0);

        // Single producer stream 0x11..0x16.
        nxt[0] = 'h11; lim[0] = 'h16; raise_pct[0] = 100; rd_pct = 100;
        repeat (12) cycle();
        for (int k = 0; k < 6; k++)
            chk("single_order", k < wr_log.size() ? int'(wr_log[k]) : -1, 'h11 + k);
        chk("single_count", wr_log.size(), 6);

        // Contention: alternating bursts of 4.
        do_reset(0);
        nxt[0] = 'hA0; nxt[1] = 'hB0; lim[0] = 1 << 30; lim[1] = 1 << 30;
        raise_pct[0] = 100; raise_pct[1] = 100; rd_pct = 100; drop_pct = 0;
        repeat (16) cycle();
        for (int k = 0; k < 12; k++) begin
            expv = (k < 4) ? 'hA0 + k : (k < 8) ? 'hB0 + k - 4 : 'hA0 + k - 4;
            chk("contend_order", k < wr_log.size() ? int'(wr_log[k]) : -1, expv);
        end

        // Full stall: p0 alone, no reads until full, then one read.
        do_reset(0);
        nxt[0] = 'h40; raise_pct[0] = 100; rd_pct = 0;
        repeat (25) cycle();
        chk("stored_at_full", wr_cnt, FIFO_DEPTH);
        chk("full_flag", int'(fifo_full), 1);
        chk("gnt_held_full", int'(gnt), 1);
        rd_once = 1;
        repeat (5) cycle();
        chk("stored_after_read", wr_cnt, FIFO_DEPTH + 1);
        chk("reads_done", rd_cnt, 1);

        // Async reset in the middle of a p1 burst.
        do_reset(0);
        raise_pct[0] = 100; raise_pct[1] = 100; rd_pct = 100;
        found = 0;
        for (int c = 0; c < 40 && !found; c++) begin
            cycle();
            found = (m_cur == 1) && m_beat;
        end
        chk("p1_burst_reached", int'(found), 1);
        rst = 1'b1;
        #1;
        chk("async_gnt", int'(gnt), 0);
        chk("async_wen", int'(fifo_wen), 0);
        chk("async_busy", int'(busy), 0);
        chk("async_ready", int'(req_ready), 0);
        do_reset(1);
        raise_pct[0] = 100; raise_pct[1] = 100;
        cycle();
        chk("post_reset_p0_wins", int'(gnt), 1);

        // Randomised traffic with drops and FIFO back-pressure.
        do_reset(0);
        raise_pct[0] = 50; raise_pct[1] = 50; drop_pct = 30; rd_pct = 45;
        repeat (600) cycle();
        raise_pct[0] = 0; raise_pct[1] = 0; drop_pct = 100; rd_pct = 100;
        repeat (40) cycle();
        chk("scoreboard_drained", dat_q.size(), 0);

        // N=3, BURST=1 fairness.
        do_reset(0);
        v3 = 3'b111;
        for (int k = 0; k < 6; k++) begin
            cycle();
            chk("n3_rr_gnt", int'(gnt3), 1 << (k % 3));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_fifo_wr_arb
